// File: rtl/alu_result_stage.sv
// Sequencing and writeback stage around the relay adder: latches operands, waits for the
// adder to settle, then writes the selected result to A or D and updates the flags.
module alu_result_stage #(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] func,
  input  logic       dest_sel,
  input  logic [7:0] b,
  input  logic [7:0] c,
  output logic [7:0] operand_b_out,
  output logic [7:0] operand_c_out,
  input  logic [7:0] adder_out,
  input  logic       adder_carry,
  output logic [7:0] reg_a,
  output logic [7:0] reg_d,
  output logic       flag_sign,
  output logic       flag_carry,
  output logic       flag_zero,
  output logic       done
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

  localparam logic [2:0] FnAdd = 3'b000;
  localparam logic [2:0] FnInc = 3'b001;
  localparam logic [2:0] FnAnd = 3'b010;
  localparam logic [2:0] FnOr  = 3'b011;
  localparam logic [2:0] FnXor = 3'b100;
  localparam logic [2:0] FnNot = 3'b101;
  localparam logic [2:0] FnShl = 3'b110;

  typedef enum logic [1:0] {StIdle, StSettle, StLatch} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      func_q;
  logic            dest_q;
  logic            accept;
  logic            writeback;
  logic [7:0]      result;
  logic            carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (op_valid) begin
          state_d = StSettle;
          cnt_d   = CntLoad;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StLatch;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StLatch: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_ready  = (state_q == StIdle);
    accept    = op_ready && op_valid;
    writeback = (state_q == StLatch);
  end

  // The captured operands are the adder inputs themselves, so logic ops reuse them.
  always_comb begin
    result = 8'h00;
    carry  = 1'b0;
    case (func_q)
      FnAdd, FnInc: begin
        result = adder_out;
        carry  = adder_carry;
      end
      FnAnd:   result = operand_b_out & operand_c_out;
      FnOr:    result = operand_b_out | operand_c_out;
      FnXor:   result = operand_b_out ^ operand_c_out;
      FnNot:   result = ~operand_b_out;
      FnShl:   result = {operand_b_out[6:0], operand_b_out[7]};
      default: result = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q        <= 3'b000;
      dest_q        <= 1'b0;
      operand_b_out <= 8'h00;
      operand_c_out <= 8'h00;
      reg_a         <= 8'h00;
      reg_d         <= 8'h00;
      flag_sign     <= 1'b0;
      flag_carry    <= 1'b0;
      flag_zero     <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= writeback;
      if (accept) begin
        func_q        <= func;
        dest_q        <= dest_sel;
        operand_b_out <= b;
        operand_c_out <= (func == FnInc) ? 8'h01 : c;
      end
      if (writeback) begin
        if (dest_q) begin
          reg_d <= result;
        end else begin
          reg_a <= result;
        end
        flag_sign  <= result[7];
        flag_zero  <= (result == 8'h00);
        flag_carry <= carry;
      end
    end
  end

endmodule
